// File: rtl/host_cmd_ctrl_pkg.sv
// Shared types and constants for the host command sequencer: FSM/phase
// encodings, header field positions and a combinational header decoder.
package host_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_BUS   = 3'd3,
    ST_PUSH  = 3'd4
  } state_t;

  // Which byte of the command stream the next LATCH captures.
  typedef enum logic [1:0] {
    PH_HDR  = 2'd0,
    PH_ADDR = 2'd1,
    PH_DATA = 2'd2
  } phase_t;

  localparam int   HDR_RW_BIT  = 7;
  localparam int   HDR_LEN_MSB = 3;
  localparam int   HDR_LEN_LSB = 0;
  localparam logic CMD_WR      = 1'b1;

  typedef struct packed {
    logic       wr;
    logic [3:0] len_m1;
  } hdr_t;

  function automatic hdr_t hdr_decode(input logic [7:0] b);
    hdr_t h;
    h.wr     = (b[HDR_RW_BIT] == CMD_WR);
    h.len_m1 = b[HDR_LEN_MSB:HDR_LEN_LSB];
    return h;
  endfunction

endpackage

// File: rtl/host_cmd_ctrl_if.sv
// FIFO-side and register-bus signals of the host command sequencer.
// master = the sequencer, slave = FIFOs plus register file.
interface host_cmd_ctrl_if;
  logic       rx_fifo_rd_en;
  logic [7:0] rx_fifo_dout;
  logic       rx_fifo_empty;
  logic       tx_fifo_wr_en;
  logic [7:0] tx_fifo_din;
  logic       tx_fifo_full;
  logic       reg_req;
  logic       reg_wr;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_ack;

  modport master (
    output rx_fifo_rd_en, input rx_fifo_dout, input rx_fifo_empty,
    output tx_fifo_wr_en, output tx_fifo_din, input tx_fifo_full,
    output reg_req, output reg_wr, output reg_addr, output reg_wdata,
    input  reg_rdata, input reg_ack
  );

  modport slave (
    input  rx_fifo_rd_en, output rx_fifo_dout, output rx_fifo_empty,
    input  tx_fifo_wr_en, input tx_fifo_din, output tx_fifo_full,
    input  reg_req, input reg_wr, input reg_addr, input reg_wdata,
    output reg_rdata, output reg_ack
  );
endinterface

// File: rtl/host_cmd_ctrl.sv
// Host command sequencer: parses RX FIFO bytes into register read/write bursts
// and returns read data (or ERR_BYTE on bus timeout) through the TX FIFO.
module host_cmd_ctrl
  import host_cmd_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 64,
  parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
  input  logic             clk,
  input  logic             reset_n,
  host_cmd_ctrl_if.master  bus,
  output logic             busy,
  output logic             err,
  output state_t           dbg_state
);

  // Handshakes: rx_fifo_rd_en pops only while !rx_fifo_empty and data is taken
  // the following cycle; tx_fifo_wr_en pushes only while !tx_fifo_full;
  // reg_req is held with stable reg_wr/addr/wdata until a one-cycle reg_ack
  // or the timeout, and drops the cycle after either.

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     state, state_nxt;
  phase_t     phase;
  hdr_t       hdr;
  logic       wr_q;
  logic [3:0] cnt_q;
  logic [7:0] addr_q, wdata_q, tx_din_q, tmo_q;
  logic       err_q;
  logic       ack_ok, tmo_hit, bus_done, last;

  assign hdr      = hdr_decode(bus.rx_fifo_dout);
  assign ack_ok   = (state == ST_BUS) && bus.reg_ack;
  assign tmo_hit  = (state == ST_BUS) && !bus.reg_ack && (tmo_q == TMO_LAST);
  assign bus_done = ack_ok || tmo_hit;
  assign last     = (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!bus.rx_fifo_empty) state_nxt = ST_FETCH;
      ST_FETCH: if (!bus.rx_fifo_empty) state_nxt = ST_LATCH;
      ST_LATCH: begin
        case (phase)
          PH_HDR:  state_nxt = ST_FETCH;
          PH_ADDR: state_nxt = wr_q ? ST_FETCH : ST_BUS;
          PH_DATA: state_nxt = ST_BUS;
          default: state_nxt = ST_IDLE;
        endcase
      end
      ST_BUS: begin
        if (bus_done) begin
          if (wr_q) state_nxt = last ? ST_IDLE : ST_FETCH;
          else      state_nxt = ST_PUSH;
        end
      end
      ST_PUSH:  if (!bus.tx_fifo_full) state_nxt = last ? ST_IDLE : ST_BUS;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.rx_fifo_rd_en = (state == ST_FETCH) && !bus.rx_fifo_empty;
    bus.reg_req       = (state == ST_BUS);
    bus.tx_fifo_wr_en = (state == ST_PUSH) && !bus.tx_fifo_full;
    busy              = (state != ST_IDLE);
  end

  assign bus.reg_wr    = wr_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.tx_fifo_din = tx_din_q;
  assign err           = err_q;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= PH_HDR;
      wr_q     <= 1'b0;
      cnt_q    <= 4'd0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      tx_din_q <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_LATCH: begin
          case (phase)
            PH_HDR: begin
              wr_q  <= hdr.wr;
              cnt_q <= hdr.len_m1;
              phase <= PH_ADDR;
            end
            PH_ADDR: begin
              addr_q <= bus.rx_fifo_dout;
              phase  <= PH_DATA;
            end
            PH_DATA: wdata_q <= bus.rx_fifo_dout;
            default: phase   <= PH_HDR;
          endcase
        end
        ST_BUS: begin
          if (bus_done) begin
            if (tmo_hit) err_q <= 1'b1;
            // A timed-out write is dropped but the burst advances as if acked.
            if (wr_q) begin
              addr_q <= addr_q + 8'd1;
              cnt_q  <= cnt_q - 4'd1;
              if (last) phase <= PH_HDR;
            end else begin
              tx_din_q <= ack_ok ? bus.reg_rdata : ERR_BYTE;
            end
          end
        end
        ST_PUSH: begin
          if (!bus.tx_fifo_full) begin
            addr_q <= addr_q + 8'd1;
            cnt_q  <= cnt_q - 4'd1;
            if (last) phase <= PH_HDR;
          end
        end
        default: ;
      endcase
    end
  end

  // Counts cycles spent in the current BUS visit; zero on every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        tmo_q <= 8'h00;
    else if (state == ST_BUS && !bus_done) tmo_q <= tmo_q + 8'd1;
    else                                 tmo_q <= 8'h00;
  end

endmodule
